// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment display decoder: debounces each digit strobe, assembles 4-digit
// frames and publishes a BCD value once CONFIRM identical clean frames are seen.
// Optional decimal-point capture is enabled with SEG7_DP_EN.
//
// state   | meaning
// COLLECT | gathering digit captures until all four positions are seen
// EVAL    | one-cycle frame judgement (error / match counting / output load)
module seg7_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int CONFIRM    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
`ifdef SEG7_DP_EN
    input  logic        dp_in,
    output logic [3:0]  dp_out,
`endif
    output logic [15:0] bcd_out,
    output logic        valid,
    output logic        frame_err
);

`ifdef SEG7_DP_EN
    localparam int SW = 12;
    localparam int FW = 20;
`else
    localparam int SW = 11;
    localparam int FW = 16;
`endif

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYC - 2);
    localparam logic [7:0] SAT_CNT = 8'(STABLE_CYC - 1);
    localparam logic [3:0] CONF    = 4'(CONFIRM);

    typedef enum logic {COLLECT, EVAL} state_t;

    state_t          state;
    logic [SW-1:0]   samp, prev_samp;
    logic [7:0]      stab_cnt;
    logic [15:0]     digit_q;
    logic [FW-1:0]   frame, prev_frame;
    logic [3:0]      seen;
    logic            bad;
    logic [3:0]      match_cnt;
    logic            onehot, same, capture, load_en;
    logic [1:0]      pos;
    logic [4:0]      dec;

`ifdef SEG7_DP_EN
    logic [3:0]      dpd_q;
    assign samp  = {dp_in, dig_sel, seg_in};
    assign frame = {dpd_q, digit_q};
`else
    assign samp  = {dig_sel, seg_in};
    assign frame = digit_q;
`endif

    // Returns {illegal, value}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
            default:    decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        onehot  = (dig_sel != 4'b0000) && ((dig_sel & (dig_sel - 4'd1)) == 4'b0000);
        same    = (samp == prev_samp);
        // stab_cnt holds (cycles held - 1), so this fires on the STABLE_CYC-th cycle only
        capture = same && onehot && (stab_cnt == CAP_CNT);
        dec     = decode(seg_in);
        case (dig_sel)
            4'b0001: pos = 2'd0;
            4'b0010: pos = 2'd1;
            4'b0100: pos = 2'd2;
            default: pos = 2'd3;
        endcase
        load_en = 1'b0;
        if (state == EVAL && !bad) begin
            if (frame == prev_frame)
                load_en = (match_cnt != CONF) && ((match_cnt + 4'd1) == CONF);
            else
                load_en = (CONF == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_samp <= '0;
            stab_cnt  <= '0;
        end else begin
            prev_samp <= samp;
            if (same && onehot) begin
                if (stab_cnt != SAT_CNT)
                    stab_cnt <= stab_cnt + 8'd1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            digit_q    <= '0;
            seen       <= '0;
            bad        <= 1'b0;
            prev_frame <= '0;
            match_cnt  <= '0;
            bcd_out    <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SEG7_DP_EN
            dpd_q      <= '0;
            dp_out     <= '0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (capture) begin
                        seen <= seen | dig_sel;
                        if (dec[4])
                            bad <= 1'b1;
                        else
                            digit_q[{pos, 2'b00} +: 4] <= dec[3:0];
`ifdef SEG7_DP_EN
                        dpd_q[pos] <= dp_in;
`endif
                        if ((seen | dig_sel) == 4'b1111)
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    state <= COLLECT;
                    seen  <= '0;
                    bad   <= 1'b0;
                    if (bad) begin
                        frame_err <= 1'b1;
                        match_cnt <= '0;
                    end else if (frame == prev_frame) begin
                        if (match_cnt != CONF)
                            match_cnt <= match_cnt + 4'd1;
                    end else begin
                        prev_frame <= frame;
                        match_cnt  <= 4'd1;
                    end
                    if (load_en) begin
                        bcd_out <= digit_q;
                        valid   <= 1'b1;
`ifdef SEG7_DP_EN
                        dp_out  <= dpd_q;
`endif
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: table of scanned frames plus hand-written
// sequences for strobe glitches and mid-frame reset; SEG7_DP_EN adds the decimal-point case.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic        valid;
    logic        frame_err;
    logic [3:0]  dp_obs;
`ifdef SEG7_DP_EN
    logic        dp_in;
    logic [3:0]  dp_out;
    assign dp_obs = dp_out;
`else
    assign dp_obs = 4'b0000;
`endif

    seg7_scan_decoder #(.STABLE_CYC(4), .CONFIRM(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
`ifdef SEG7_DP_EN
        .dp_in     (dp_in),
        .dp_out    (dp_out),
`endif
        .bcd_out   (bcd_out),
        .valid     (valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;   // nibble i shown on dig_sel[i]; 4'hF = blank
        logic [3:0]  dp;
        bit          exp_valid;
        bit          exp_err;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t        tbl [8];
    logic [19:0] exp_q [$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_valid = 0;
    int          n_err   = 0;

    function automatic logic [6:0] to_seg(input logic [3:0] v);
        case (v)
            4'd0: to_seg = 7'h7E;
            4'd1: to_seg = 7'h30;
            4'd2: to_seg = 7'h6D;
            4'd3: to_seg = 7'h79;
            4'd4: to_seg = 7'h33;
            4'd5: to_seg = 7'h5B;
            4'd6: to_seg = 7'h5F;
            4'd7: to_seg = 7'h70;
            4'd8: to_seg = 7'h7F;
            4'd9: to_seg = 7'h7B;
            default: to_seg = 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: each valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("valid_data", {12'd0, dp_obs, bcd_out}, {12'd0, exp_q.pop_front()});
            end
            if (frame_err) n_err++;
        end
    end

    task automatic drive_digit(input int d, input logic [6:0] seg, input int hold);
        dig_sel = 4'(1 << d);
        seg_in  = seg;
        repeat (hold) @(negedge clk);
    endtask

    task automatic scan_frame(input vec_t v, input int hold);
        for (int d = 0; d < 4; d++) begin
`ifdef SEG7_DP_EN
            dp_in = v.dp[d];
`endif
            drive_digit(d, to_seg(v.digits[d*4 +: 4]), hold);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        if (v.exp_valid) exp_q.push_back({v.dp, v.exp_bcd});
        scan_frame(v, 6);
        #1;
        check({name, "_valid"}, 32'(n_valid - v0), 32'(v.exp_valid));
        check({name, "_err"},   32'(n_err - e0),   32'(v.exp_err));
        check({name, "_bcd"},   {16'd0, bcd_out},  {16'd0, v.exp_bcd});
    endtask

    initial begin
        int   v0, e0;
        vec_t hv;

        tbl[0] = '{16'h4321, 4'b0000, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{16'h4321, 4'b0000, 1'b1, 1'b0, 16'h4321};
        tbl[2] = '{16'h4321, 4'b0000, 1'b0, 1'b0, 16'h4321};
        tbl[3] = '{16'h1234, 4'b0000, 1'b0, 1'b0, 16'h4321};
        tbl[4] = '{16'h1234, 4'b0000, 1'b1, 1'b0, 16'h1234};
        tbl[5] = '{16'h8F65, 4'b0000, 1'b0, 1'b1, 16'h1234};
        tbl[6] = '{16'h8765, 4'b0000, 1'b0, 1'b0, 16'h1234};
        tbl[7] = '{16'h8765, 4'b0000, 1'b1, 1'b0, 16'h8765};

        rst_n   = 1'b0;
        seg_in  = 7'h00;
        dig_sel = 4'b0000;
`ifdef SEG7_DP_EN
        dp_in   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_bcd",   {16'd0, bcd_out}, 32'd0);
        check("rst_valid", {31'd0, valid},   32'd0);
        check("rst_err",   {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Non-one-hot strobe and a segment line that never settles long enough
        v0 = n_valid;
        e0 = n_err;
        drive_digit(0, to_seg(4'd2), 6);
        drive_digit(1, to_seg(4'd4), 6);
        dig_sel = 4'b0011;
        seg_in  = 7'h00;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 8; k++)
            drive_digit(2, (k % 2 == 0) ? 7'h00 : to_seg(4'd6), 3);
        drive_digit(2, to_seg(4'd6), 6);
        drive_digit(3, to_seg(4'd8), 6);
        #1;
        check("glitch_err",   32'(n_err - e0),   32'd0);
        check("glitch_valid", 32'(n_valid - v0), 32'd0);
        hv = '{16'h8642, 4'b0000, 1'b1, 1'b0, 16'h8642};
        run_vec("glitch_confirm", hv);

        // Reset in the middle of a frame
        drive_digit(0, to_seg(4'd9), 6);
        drive_digit(1, to_seg(4'd0), 6);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd",   {16'd0, bcd_out}, 32'd0);
        check("midrst_valid", {31'd0, valid},   32'd0);
        check("midrst_err",   {31'd0, frame_err}, 32'd0);
        check("midrst_dp",    {28'd0, dp_obs},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hv = '{16'h9009, 4'b0000, 1'b0, 1'b0, 16'h0000};
        run_vec("post_rst1", hv);
        hv = '{16'h9009, 4'b0000, 1'b1, 1'b0, 16'h9009};
        run_vec("post_rst2", hv);

`ifdef SEG7_DP_EN
        hv = '{16'h9009, 4'b0010, 1'b0, 1'b0, 16'h9009};
        run_vec("dp1", hv);
        hv = '{16'h9009, 4'b0010, 1'b1, 1'b0, 16'h9009};
        run_vec("dp2", hv);
        check("dp_out", {28'd0, dp_obs}, 32'h2);
`endif

        dig_sel = 4'b0000;
        seg_in  = 7'h00;
        repeat (8) @(negedge clk);
        #1;
        check("pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
